// File: rtl/gbc_mbc1_mapper.sv
// MBC1 cartridge mapper: decodes bank-select register writes and translates bus
// reads/writes into backing-store requests (ROM region bit 21 = 0, RAM region bit 21 = 1).
module gbc_mbc1_mapper #(
    parameter logic [6:0] RomBankMask = 7'h7F,
    parameter logic [1:0] RamBankMask = 2'h3,
    parameter bit         HasRam      = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ClkEn,
    input  logic [15:0] Address,
    input  logic [7:0]  DToTarget,
    input  logic        Access,
    input  logic        Write,
    input  logic        Mask,
    output logic [7:0]  DToInitiator,
    output logic        Ready,
    output logic        DataReady,
    output logic [21:0] MemAddress,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [7:0]  MemWData,
    input  logic [7:0]  MemRData,
    input  logic        MemAck
);

    typedef enum logic [1:0] {StIdle, StReg, StMem, StDone} state_e;

    state_e      state_q, state_d;
    logic        ram_en_q, ram_en_d;
    logic [4:0]  bank_lo_q, bank_lo_d;
    logic [1:0]  bank_hi_q, bank_hi_d;
    logic        mode_q, mode_d;
    logic [7:0]  dout_q, dout_d;
    logic [21:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_rdata_q, mem_rdata_d;
    logic        ack_q, ack_d;
    logic        is_read_q, is_read_d;

    logic       accept;
    logic       is_rom;
    logic       is_ram;
    logic       ram_on;
    logic [6:0] rom_bank;
    logic [1:0] ram_bank;

    assign Ready        = (state_q == StIdle) || (state_q == StDone);
    assign DataReady    = (state_q == StReg) || (state_q == StDone);
    assign DToInitiator = dout_q;
    assign MemAddress   = mem_addr_q;
    assign MemRead      = mem_rd_q;
    assign MemWrite     = mem_wr_q;
    assign MemWData     = mem_wdata_q;

    assign accept = ClkEn && Ready && Access;
    assign is_rom = ~Address[15];
    assign is_ram = (Address[15:13] == 3'b101);
    assign ram_on = HasRam && ram_en_q;

    // Bank translation for the current bus address
    always_comb begin
        if (Address[14]) begin
            rom_bank = {bank_hi_q, bank_lo_q} & RomBankMask;
        end else begin
            rom_bank = (mode_q ? {bank_hi_q, 5'b0} : 7'd0) & RomBankMask;
        end
        ram_bank = (mode_q ? bank_hi_q : 2'b00) & RamBankMask;
    end

    // Next-state: request decode, register writes, memory handshake
    always_comb begin
        state_d     = state_q;
        ram_en_d    = ram_en_q;
        bank_lo_d   = bank_lo_q;
        bank_hi_d   = bank_hi_q;
        mode_d      = mode_q;
        dout_d      = dout_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rdata_d = mem_rdata_q;
        ack_d       = ack_q;
        is_read_d   = is_read_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone && ClkEn) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    is_read_d = ~Write;
                    ack_d     = 1'b0;
                    if (is_rom && !Write) begin
                        state_d    = StMem;
                        mem_addr_d = {1'b0, rom_bank, Address[13:0]};
                        mem_rd_d   = 1'b1;
                    end else if (is_ram && ram_on && !(Write && !Mask)) begin
                        state_d     = StMem;
                        mem_addr_d  = {1'b1, 6'b0, ram_bank, Address[12:0]};
                        mem_rd_d    = ~Write;
                        mem_wr_d    = Write;
                        mem_wdata_d = DToTarget;
                    end else begin
                        // Register write, masked write, undecoded or disabled RAM
                        state_d = StReg;
                        if (!Write) begin
                            dout_d = 8'hFF;
                        end
                        if (is_rom && Write && Mask) begin
                            unique case (Address[14:13])
                                2'd0: ram_en_d  = (DToTarget[3:0] == 4'hA);
                                2'd1: bank_lo_d = (DToTarget[4:0] == 5'd0) ? 5'd1 : DToTarget[4:0];
                                2'd2: bank_hi_d = DToTarget[1:0];
                                2'd3: mode_d    = DToTarget[0];
                                default: ;
                            endcase
                        end
                    end
                end
            end
            StReg: begin
                if (ClkEn) begin
                    state_d = StIdle;
                end
            end
            StMem: begin
                // The ack is latched on every edge so a pulse during ClkEn=0 is not lost
                if (MemAck) begin
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    mem_rdata_d = MemRData;
                    ack_d       = 1'b1;
                end
                if (ClkEn && (ack_q || MemAck)) begin
                    state_d = StDone;
                    ack_d   = 1'b0;
                    if (is_read_q) begin
                        dout_d = MemAck ? MemRData : mem_rdata_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and register storage with asynchronous reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            ram_en_q    <= 1'b0;
            bank_lo_q   <= 5'd1;
            bank_hi_q   <= 2'd0;
            mode_q      <= 1'b0;
            dout_q      <= 8'hFF;
            mem_addr_q  <= 22'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
            mem_rdata_q <= 8'd0;
            ack_q       <= 1'b0;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            bank_lo_q   <= bank_lo_d;
            bank_hi_q   <= bank_hi_d;
            mode_q      <= mode_d;
            dout_q      <= dout_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rdata_q <= mem_rdata_d;
            ack_q       <= ack_d;
            is_read_q   <= is_read_d;
        end
    end

endmodule

// File: doc/gbc_mbc1_mapper.md
GBC_MBC1_MAPPER -- requirements
Module: gbc_mbc1_mapper

Interface
REQ-001 SHALL have parameter RomBankMask, default 7'h7F, ANDed onto every ROM bank number (ROM size select).
REQ-002 SHALL have parameter RamBankMask, default 2'h3, ANDed onto every RAM bank number.
REQ-003 SHALL have parameter HasRam, default 1; when 0, the $A000-$BFFF window behaves as disabled RAM.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports, as name direction width meaning:
- Clk in 1: system clock.
- Reset in 1: asynchronous, active-high reset.
- ClkEn in 1: bus-side clock enable.
- Address in 16: bus address.
- DToTarget in 8: write data.
- Access in 1: request strobe.
- Write in 1: 1 = write, 0 = read.
- Mask in 1: byte enable; a write with Mask=0 changes nothing.
- DToInitiator out 8: read data.
- Ready out 1: target can accept a request.
- DataReady out 1: one-cycle completion pulse.
- MemAddress out 22: backing-store address; bit 21 = 1 selects the RAM region.
- MemRead out 1: backing-store read request.
- MemWrite out 1: backing-store write request.
- MemWData out 8: backing-store write data.
- MemRData in 8: backing-store read data.
- MemAck in 1: single-Clk pulse, request complete.
REQ-006 Bus-side ports SHALL form the IRetroMemoryPort target end, answering the cartridge controller's Mapper initiator.

Function
REQ-007 Registers:
- RamEn: write to $0000-$1FFF sets it iff DToTarget[3:0]==4'hA, else clears it.
- BankLo[4:0]: write to $2000-$3FFF; a written value of 0 stores 1.
- BankHi[1:0]: write to $4000-$5FFF, from DToTarget[1:0].
- Mode: write to $6000-$7FFF, from DToTarget[0].
REQ-008 ROM reads SHALL map as follows, with bank ANDed with RomBankMask:
- $0000-$3FFF: bank = Mode ? {BankHi,5'b0} : 0.
- $4000-$7FFF: bank = {BankHi,BankLo}.
- MemAddress = {1'b0, bank[6:0], Address[13:0]}.
REQ-009 RAM ($A000-$BFFF) SHALL map as: bank = (Mode ? BankHi : 0) & RamBankMask; MemAddress = {1'b1, 6'b0, bank, Address[12:0]}.
REQ-010 States:
- IDLE: Ready=1.
- REG: one cycle.
- MEM: Ready=0, MemRead or MemWrite held.
- DONE: DataReady=1, Ready=1.
REQ-011 A request is accepted only when ClkEn=1, Ready=1 and Access=1; Access at any other time SHALL be ignored.
REQ-012 Register writes, undecoded addresses, and disabled RAM (RamEn=0 or HasRam=0) SHALL go IDLE->REG->IDLE. DataReady pulses on the REG cycle, which is 1 enabled cycle after acceptance. Reads on these paths return 8'hFF; writes are dropped.
REQ-013 ROM reads and enabled-RAM accesses SHALL go IDLE->MEM. MemAddress, MemWData and the request strobe are registered at acceptance and held stable until MemAck.
REQ-014 The cycle after MemAck, the block SHALL be in DONE: DToInitiator = captured MemRData (reads), DataReady=1. It returns to IDLE on the next enabled cycle.
REQ-015 Writes to ROM space SHALL update registers only; they SHALL NOT assert MemWrite.
REQ-016 MemAck SHALL be captured on every Clk edge regardless of ClkEn (sticky flag); state transitions advance only when ClkEn=1.
REQ-017 MemAck arriving outside MEM SHALL be ignored.
REQ-018 DToInitiator SHALL hold its last value except on a completion cycle.
REQ-019 A write with Mask=0 SHALL complete normally with no register or memory change and no MemWrite.

Reset
REQ-020 On Reset (asynchronous, mid-operation included) the block SHALL enter IDLE with: RamEn=0, BankLo=1, BankHi=0, Mode=0, Ready=1, DataReady=0, DToInitiator=8'hFF, MemRead=0, MemWrite=0, MemAddress=0, ack flag cleared.
REQ-021 An access in flight at reset SHALL be abandoned; a MemAck arriving after reset is discarded.

Verification
REQ-022 Write $2000=8'h00, then read $4000 -> MemAddress=22'h004000, MemRead until MemAck, DataReady 1 cycle after ack.
REQ-023 Write $4000=8'h01, $6000=8'h01, $2000=8'h03, then read $0123 -> MemAddress = {0, 7'h20, 14'h0123}. Read $4123 -> bank 7'h23.
REQ-024 Read $A000 with RamEn=0 -> 8'hFF, DataReady 1 cycle after acceptance, no MemRead. Then write $0000=8'h0A and write $A010=8'h5C -> MemWrite, MemAddress=22'h200010, MemWData=8'h5C.
REQ-025 ClkEn toggling 1/0, with MemAck pulsed while ClkEn=0 -> ack not lost; DONE on the next enabled cycle.
REQ-026 Assert Reset during MEM, then pulse MemAck after release -> MemRead=0, Ready=1, no DataReady, registers at reset values.
